mc_datapath: RTL and testbench

Multi-cycle, width-parametrised successor to the single-cycle 16-bit datapath. It contains its own 2^RF_ADDR_W-entry register file and ALU. It accepts one 16-bit instruction plus decoded control bits through a valid/ready handshake, then executes it over a fixed three-state sequence. It sits between the control unit / instruction source and the output port logic, and adds a registered output port, status flags and a completion pulse.

---
 rtl/mc_datapath.sv | 156 +++++++++++++++
 tb/tb_mc_datapath.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath.sv
// Multi-cycle datapath: register file, ALU and registered output port, executing one
// handshaked instruction over an IDLE -> EXEC -> WB sequence.
module mc_datapath #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RF_ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instruction,
  input  logic              alu_src,
  input  logic              reg_dst,
  input  logic              reg_write,
  input  logic              imm_to_reg,
  input  logic              out_en,
  input  logic [3:0]        alu_op,
  output logic [DATA_W-1:0] output_port,
  output logic              out_valid,
  output logic              done,
  output logic              zero_flag,
  output logic              carry_flag
);

  localparam int unsigned NumRegs = 2 ** RF_ADDR_W;

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e state_q, state_d;

  logic [15:0]          instr_q;
  logic                 alu_src_q, reg_dst_q, reg_write_q, imm_to_reg_q, out_en_q;
  logic [3:0]           alu_op_q;
  logic [DATA_W-1:0]    rf_q [NumRegs];
  logic [DATA_W-1:0]    alu_res_q;
  logic [DATA_W-1:0]    out_q;
  logic                 out_valid_q, zero_q, carry_q;

  logic [RF_ADDR_W-1:0] rs, rt, rd, dest;
  logic [7:0]           imm;
  logic [DATA_W-1:0]    imm_sext, imm_upper, op_a, op_b, alu_res, wb_data;
  logic [DATA_W:0]      sum, diff;
  logic                 alu_carry;
  logic                 unused_instr;

  // Fields may overlap for wider register addresses; that is the decoder's format.
  assign rs   = instr_q[11 -: RF_ADDR_W];
  assign rt   = instr_q[9 -: RF_ADDR_W];
  assign rd   = instr_q[7 -: RF_ADDR_W];
  assign imm  = instr_q[7:0];
  assign dest = reg_dst_q ? rd : rt;

  assign unused_instr = ^instr_q;

  assign imm_sext = {{(DATA_W - 8){imm[7]}}, imm};

  always_comb begin
    imm_upper       = '0;
    imm_upper[15:8] = imm;
  end

  assign op_a    = rf_q[rs];
  assign op_b    = alu_src_q ? imm_sext : rf_q[rt];
  assign wb_data = imm_to_reg_q ? imm_upper : alu_res_q;

  // diff carry-out is the inverted borrow of A - B.
  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} + {1'b0, ~op_b} + (DATA_W + 1)'(1);

  always_comb begin
    alu_res   = op_a;
    alu_carry = carry_q;
    case (alu_op_q)
      4'd0: begin
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      4'd1: begin
        alu_res   = diff[DATA_W-1:0];
        alu_carry = diff[DATA_W];
      end
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = ~op_a;
      4'd5:    alu_res = op_a ^ op_b;
      4'd6:    alu_res = {op_a[DATA_W-2:0], 1'b0};
      4'd7:    alu_res = {op_a[DATA_W-1], op_a[DATA_W-1:1]};
      default: alu_res = op_a;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (instr_valid) state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign instr_ready = (state_q == StIdle);
  assign done        = (state_q == StWb);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      instr_q      <= '0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      imm_to_reg_q <= 1'b0;
      out_en_q     <= 1'b0;
      alu_op_q     <= '0;
      alu_res_q    <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
      for (int unsigned i = 0; i < NumRegs; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      if (state_q == StIdle && instr_valid) begin
        instr_q      <= instruction;
        alu_src_q    <= alu_src;
        reg_dst_q    <= reg_dst;
        reg_write_q  <= reg_write;
        imm_to_reg_q <= imm_to_reg;
        out_en_q     <= out_en;
        alu_op_q     <= alu_op;
      end
      if (state_q == StExec) begin
        alu_res_q <= alu_res;
        zero_q    <= (alu_res == '0);
        carry_q   <= alu_carry;
        if (out_en_q) begin
          out_q       <= op_a;
          out_valid_q <= 1'b1;
        end
      end
      // Write-back lands after the EXEC read, so out_en sees the pre-write value.
      if (state_q == StWb && reg_write_q) begin
        rf_q[dest] <= wb_data;
      end
    end
  end

  assign output_port = out_q;
  assign out_valid   = out_valid_q;
  assign zero_flag   = zero_q;
  assign carry_flag  = carry_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: a 16-bit and a 32-bit instance share stimulus and are checked
// against a width-generic instruction-level model plus a table of hand-computed vectors.
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        reset_n, instr_valid;
  logic [15:0] instruction;
  logic        alu_src, reg_dst, reg_write, imm_to_reg, out_en;
  logic [3:0]  alu_op;

  logic        rdy16, rdy32, ov16, ov32, done16, done32, z16, z32, c16, c32;
  logic [15:0] out16;
  logic [31:0] out32;

  always #5 clk = ~clk;

  mc_datapath #(.DATA_W(16), .RF_ADDR_W(2)) dut16 (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(rdy16),
    .instruction(instruction), .alu_src(alu_src), .reg_dst(reg_dst), .reg_write(reg_write),
    .imm_to_reg(imm_to_reg), .out_en(out_en), .alu_op(alu_op), .output_port(out16),
    .out_valid(ov16), .done(done16), .zero_flag(z16), .carry_flag(c16)
  );

  mc_datapath #(.DATA_W(32), .RF_ADDR_W(2)) dut32 (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(rdy32),
    .instruction(instruction), .alu_src(alu_src), .reg_dst(reg_dst), .reg_write(reg_write),
    .imm_to_reg(imm_to_reg), .out_en(out_en), .alu_op(alu_op), .output_port(out32),
    .out_valid(ov32), .done(done32), .zero_flag(z32), .carry_flag(c32)
  );

  typedef struct {
    logic [15:0] ins;
    logic        src, dst, wr, lui, oe;
    logic [3:0]  op;
  } cmd_t;

  typedef struct {
    cmd_t        c;
    logic [15:0] e_out;
    logic        e_z, e_c;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction-level model; index 0 is the 16-bit instance, 1 the 32-bit one.
  logic [31:0] m_rf [2][4];
  logic [31:0] m_out [2];
  logic        m_z [2];
  logic        m_c [2];

  logic        exp_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  vec_t        tab [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [1:0] rs, input logic [1:0] rt,
                                     input logic [7:0] imm);
    return {4'h0, rs, rt, imm};
  endfunction

  function automatic cmd_t cm(input logic [15:0] ins, input logic src, input logic dst,
                              input logic wr, input logic lui, input logic oe,
                              input logic [3:0] op);
    cmd_t c;
    c.ins = ins; c.src = src; c.dst = dst; c.wr = wr; c.lui = lui; c.oe = oe; c.op = op;
    return c;
  endfunction

  function automatic vec_t vv(input cmd_t c, input logic [15:0] eo, input logic ez,
                              input logic ec);
    vec_t v;
    v.c = c; v.e_out = eo; v.e_z = ez; v.e_c = ec;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 4; r++) m_rf[i][r] = '0;
      m_out[i] = '0;
      m_z[i]   = 1'b0;
      m_c[i]   = 1'b0;
    end
  endtask

  task automatic model_step(input cmd_t c);
    for (int i = 0; i < 2; i++) begin
      int          w;
      logic [63:0] mask, a, b, sext, res, full, imm;
      logic [1:0]  rs, rt, rd, d;
      w    = (i == 0) ? 16 : 32;
      mask = (64'd1 << w) - 64'd1;
      rs   = c.ins[11:10];
      rt   = c.ins[9:8];
      rd   = c.ins[7:6];
      imm  = {56'd0, c.ins[7:0]};
      sext = c.ins[7] ? ((mask & ~64'hFF) | imm) : imm;
      a    = {32'd0, m_rf[i][rs]};
      b    = c.src ? sext : {32'd0, m_rf[i][rt]};
      case (c.op)
        4'd0: begin
          full    = a + b;
          res     = full & mask;
          m_c[i]  = full[w];
        end
        4'd1: begin
          res    = (a - b) & mask;
          m_c[i] = (a >= b);
        end
        4'd2:    res = a & b;
        4'd3:    res = a | b;
        4'd4:    res = ~a & mask;
        4'd5:    res = a ^ b;
        4'd6:    res = (a << 1) & mask;
        4'd7:    res = (a >> 1) | (a & (64'd1 << (w - 1)));
        default: res = a;
      endcase
      m_z[i] = (res == 64'd0);
      if (c.oe) m_out[i] = a[31:0];
      d = c.dst ? rd : rt;
      if (c.wr) m_rf[i][d] = c.lui ? 32'(imm << 8) : res[31:0];
    end
  endtask

  task automatic drive(input cmd_t c);
    instruction = c.ins;
    alu_src     = c.src;
    reg_dst     = c.dst;
    reg_write   = c.wr;
    imm_to_reg  = c.lui;
    out_en      = c.oe;
    alu_op      = c.op;
  endtask

  task automatic scramble();
    instruction = 16'($urandom);
    alu_src     = 1'($urandom_range(0, 1));
    reg_dst     = 1'($urandom_range(0, 1));
    reg_write   = 1'($urandom_range(0, 1));
    imm_to_reg  = 1'($urandom_range(0, 1));
    out_en      = 1'($urandom_range(0, 1));
    alu_op      = 4'($urandom_range(0, 15));
    instr_valid = 1'($urandom_range(0, 1));
  endtask

  // Called one step after an edge with the block in IDLE; returns in the next IDLE.
  task automatic issue(input cmd_t c);
    drive(c);
    instr_valid = 1'b1;
    check("idle_ready16", rdy16, 1);
    check("idle_ready32", rdy32, 1);
    @(posedge clk); #1;
    model_step(c);
    scramble();
    check("exec_ready16", rdy16, 0);
    check("exec_done16", done16, 0);
    check("exec_done32", done32, 0);
    @(posedge clk); #1;
    check("wb_done16", done16, 1);
    check("wb_done32", done32, 1);
    check("wb_ready32", rdy32, 0);
    check("wb_ovalid16", ov16, c.oe);
    check("wb_ovalid32", ov32, c.oe);
    check("wb_out16", out16, m_out[0]);
    check("wb_out32", out32, m_out[1]);
    check("wb_zero16", z16, m_z[0]);
    check("wb_zero32", z32, m_z[1]);
    check("wb_carry16", c16, m_c[0]);
    check("wb_carry32", c32, m_c[1]);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("post_done16", done16, 0);
    check("post_ovalid16", ov16, 0);
    check("post_ovalid32", ov32, 0);
    check("post_ready16", rdy16, 1);
  endtask

  task automatic read_reg(input logic [1:0] r);
    issue(cm(mk(r, 2'd0, 8'h00), 0, 0, 0, 0, 1, 4'd8));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cmd_t a_cmd, b_cmd, rnd;
    int   d16, d32;

    for (int r = 0; r < 4; r++)
      tab[r] = vv(cm(mk(2'(r), 2'd0, 8'h00), 0, 0, 0, 0, 1, 4'd8), 16'h0000, 1, 0);
    tab[4]  = vv(cm(mk(2'd0, 2'd1, 8'h12), 0, 0, 1, 1, 0, 4'd8), 16'h0000, 1, 0);
    tab[5]  = vv(cm(mk(2'd1, 2'd0, 8'h00), 0, 0, 0, 0, 1, 4'd8), 16'h1200, 0, 0);
    tab[6]  = vv(cm(mk(2'd1, 2'd2, 8'hFF), 1, 0, 1, 0, 1, 4'd0), 16'h1200, 0, 1);
    tab[7]  = vv(cm(mk(2'd2, 2'd0, 8'h00), 0, 0, 0, 0, 1, 4'd8), 16'h11FF, 0, 1);
    tab[8]  = vv(cm(mk(2'd1, 2'd1, 8'h00), 0, 0, 0, 0, 0, 4'd1), 16'h11FF, 1, 1);
    tab[9]  = vv(cm(mk(2'd0, 2'd0, 8'hC0), 0, 1, 1, 0, 1, 4'd4), 16'h0000, 0, 1);
    tab[10] = vv(cm(mk(2'd3, 2'd0, 8'h01), 1, 0, 0, 0, 1, 4'd0), 16'hFFFF, 1, 1);
    tab[11] = vv(cm(mk(2'd2, 2'd1, 8'h00), 0, 0, 0, 0, 0, 4'd1), 16'hFFFF, 0, 0);
    tab[12] = vv(cm(mk(2'd2, 2'd0, 8'h40), 0, 1, 1, 0, 1, 4'd6), 16'h11FF, 0, 0);
    tab[13] = vv(cm(mk(2'd3, 2'd0, 8'h00), 0, 0, 0, 0, 1, 4'd7), 16'hFFFF, 0, 0);
    tab[14] = vv(cm(mk(2'd1, 2'd1, 8'h0F), 1, 0, 1, 0, 1, 4'd2), 16'h23FE, 0, 0);
    tab[15] = vv(cm(mk(2'd1, 2'd0, 8'h00), 0, 0, 0, 0, 1, 4'd8), 16'h000E, 0, 0);
    tab[16] = vv(cm(mk(2'd1, 2'd3, 8'h00), 0, 0, 0, 0, 0, 4'd3), 16'h000E, 0, 0);
    tab[17] = vv(cm(mk(2'd3, 2'd3, 8'h00), 0, 0, 0, 0, 0, 4'd5), 16'h000E, 1, 0);

    reset_n     = 1'b0;
    instr_valid = 1'b0;
    drive(cm(16'h0000, 0, 0, 0, 0, 0, 4'd0));
    repeat (2) @(posedge clk);
    #1;
    check("rst_out16", out16, 0);
    check("rst_out32", out32, 0);
    check("rst_zero16", z16, 0);
    check("rst_carry16", c16, 0);
    check("rst_ready16", rdy16, 1);
    check("rst_done16", done16, 0);
    check("rst_ovalid16", ov16, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rel_ready16", rdy16, 1);
    check("rel_ready32", rdy32, 1);
    model_reset();

    for (int k = 0; k < 18; k++) begin
      issue(tab[k].c);
      check($sformatf("tab%0d_out16", k), out16, tab[k].e_out);
      check($sformatf("tab%0d_zero16", k), z16, tab[k].e_z);
      check($sformatf("tab%0d_carry16", k), c16, tab[k].e_c);
    end

    for (int n = 0; n < 200; n++) begin
      rnd = cm(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      issue(rnd);
    end

    // instr_valid held for six cycles; B must be taken exactly once, in the next IDLE.
    a_cmd = cm(mk(2'd0, 2'd2, 8'h34), 0, 0, 1, 1, 0, 4'd8);
    b_cmd = cm(mk(2'd3, 2'd3, 8'h01), 1, 0, 1, 0, 0, 4'd0);
    d16 = 0;
    d32 = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive((cyc < 3) ? a_cmd : b_cmd);
      instr_valid = 1'b1;
      check($sformatf("hs_ready16_c%0d", cyc), rdy16, exp_rdy[cyc]);
      check($sformatf("hs_ready32_c%0d", cyc), rdy32, exp_rdy[cyc]);
      @(posedge clk); #1;
      if (done16) d16++;
      if (done32) d32++;
    end
    instr_valid = 1'b0;
    model_step(a_cmd);
    model_step(b_cmd);
    check("hs_dones16", d16, 2);
    check("hs_dones32", d32, 2);
    read_reg(2'd2);
    read_reg(2'd3);
    issue(cm(mk(2'd2, 2'd2, 8'h00), 0, 0, 0, 0, 1, 4'd1));

    // Reset lands in EXEC of a write to R3.
    drive(cm(mk(2'd0, 2'd3, 8'h77), 0, 0, 1, 1, 0, 4'd8));
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    reset_n     = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_done16", done16, 0);
    check("mid_rst_done32", done32, 0);
    check("mid_rst_ready16", rdy16, 1);
    check("mid_rst_out16", out16, 0);
    check("mid_rst_out32", out32, 0);
    check("mid_rst_zero16", z16, 0);
    check("mid_rst_carry16", c16, 0);
    check("mid_rst_carry32", c32, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_done16", done16, 0);
    check("mid_rel_ready16", rdy16, 1);
    check("mid_rel_ready32", rdy32, 1);
    model_reset();
    for (int r = 0; r < 4; r++) read_reg(2'(r));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
